// File: rtl/dmem_if.sv
// M-stage data-memory interface: req/ready bus handshake, byte enables, store-lane replication.
// Optional DMEM_MISALIGN_TRAP_EN turns misaligned accesses into a Misalign pulse with no bus request.
module dmem_if #(
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] AddrM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] MemDataM,
  output logic        MemStall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata,
  output logic        bus_err,
  output logic        Misalign
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t           state, nextState;
  logic [CNT_W-1:0] waitCnt;
  logic             accReq;
  logic             trapHit;
  logic             timeoutHit;

  function automatic logic [3:0] storeBe(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      3'b000:  return 4'b0001 << a;
      3'b001:  return 4'b0011 << {a[1], 1'b0};
      3'b010:  return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] storeData(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'b000:  return {4{d[7:0]}};
      3'b001:  return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

`ifdef DMEM_MISALIGN_TRAP_EN
  function automatic logic isMisaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      3'b001, 3'b101: return a[0];
      3'b010:         return a != 2'b00;
      default:        return 1'b0;
    endcase
  endfunction

  assign trapHit = accReq & isMisaligned(Funct3M, AddrM[1:0]);
`else
  assign trapHit = 1'b0;
`endif

  assign accReq     = MemReadM | MemWriteM;
  assign timeoutHit = (TIMEOUT != 0) && !bus_ready && ((waitCnt + 1'b1) == TO_CNT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    MemStall  = 1'b0;
    case (state)
      IDLE: begin
        if (accReq) begin
          MemStall  = 1'b1;
          nextState = trapHit ? DONE : ACCESS;
        end
      end
      ACCESS: begin
        MemStall = 1'b1;
        if (bus_ready || timeoutHit) nextState = DONE;
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Bus request capture, completion and timeout abort
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      MemDataM  <= 32'h0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'h0;
      bus_be    <= 4'h0;
      bus_wdata <= 32'h0;
      bus_err   <= 1'b0;
      Misalign  <= 1'b0;
      waitCnt   <= '0;
    end else begin
      bus_err  <= 1'b0;
      Misalign <= (state == IDLE) && trapHit;
      case (state)
        IDLE: begin
          waitCnt <= '0;
          if (accReq && !trapHit) begin
            bus_req  <= 1'b1;
            bus_we   <= MemWriteM;
            bus_addr <= {AddrM[31:2], 2'b00};
            if (MemWriteM) begin
              bus_be    <= storeBe(Funct3M, AddrM[1:0]);
              bus_wdata <= storeData(Funct3M, WriteDataM);
            end else begin
              bus_be    <= 4'b1111;
            end
          end
        end
        ACCESS: begin
          if (bus_ready) begin
            bus_req <= 1'b0;
            if (!bus_we) MemDataM <= bus_rdata;
          end else if (timeoutHit) begin
            bus_req  <= 1'b0;
            MemDataM <= ERR_DATA;
            bus_err  <= 1'b1;
          end else begin
            waitCnt <= waitCnt + 1'b1;
          end
        end
        default: waitCnt <= '0;
      endcase
    end
  end

endmodule
